// File: rtl/mem_block_responder.sv
// Memory-side responder for D-cache (port 0) and I-cache (port 1): single-word writes and 8-word block reads.
// Optional ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of port 0 always winning.
module mem_block_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  wr0,
   input  logic                  wr1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [15:0]           wdata0,
   input  logic [15:0]           wdata1,
   output logic                  arbiter_select,
   output logic                  busy,
   output logic [15:0]           rdata,
   output logic                  rvalid,
   output logic [2:0]            word_idx,
   output logic                  done
);

   // state   | meaning
   // IDLE    | waiting for req0/req1, accepts on the same cycle
   // WAIT    | latency countdown after accept
   // BURST   | streaming block words 0..7 on rdata
   // DONE    | one-cycle done pulse; write commits at the end of this cycle
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int CNT_W = $clog2(LATENCY);
   localparam int WA_W  = ADDR_WIDTH - 1;

   logic [15:0]      mem [0:(2**WA_W)-1];
   logic [1:0]       state;
   logic [CNT_W-1:0] lat_cnt;
   logic [WA_W-1:0]  addr_q;
   logic [15:0]      wdata_q;
   logic             wr_q;
   logic             grant1;
   logic [2:0]       rd_k;
   logic [WA_W-1:0]  rd_addr;
   logic             unused_lsb;

   assign unused_lsb = addr0[0] ^ addr1[0];
   assign busy       = (state != ST_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   assign grant1 = req1 & (~req0 | ~last_grant);

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b0;
      else if (state == ST_IDLE && (req0 || req1))
         last_grant <= grant1;
   end
`else
   assign grant1 = req1 & ~req0;
`endif

   // Burst always starts at word 0 of the block regardless of the latched offset.
   always_comb begin
      rd_k    = (state == ST_BURST) ? word_idx + 3'd1 : 3'd0;
      rd_addr = {addr_q[WA_W-1:3], rd_k};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         arbiter_select <= 1'b0;
         rdata          <= '0;
         rvalid         <= 1'b0;
         word_idx       <= '0;
         done           <= 1'b0;
         lat_cnt        <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         wr_q           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req0 || req1) begin
                  arbiter_select <= grant1;
                  wr_q           <= grant1 ? wr1 : wr0;
                  addr_q         <= grant1 ? addr1[ADDR_WIDTH-1:1] : addr0[ADDR_WIDTH-1:1];
                  wdata_q        <= grant1 ? wdata1 : wdata0;
                  lat_cnt        <= CNT_W'(LATENCY - 1);
                  state          <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               // Leaving at count 1 makes the registered outputs appear exactly LATENCY cycles after accept.
               if (lat_cnt == CNT_W'(1)) begin
                  if (wr_q) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= ST_BURST;
                     rvalid   <= 1'b1;
                     rdata    <= mem[rd_addr];
                     word_idx <= 3'd0;
                  end
               end
            end
            ST_BURST: begin
               if (word_idx == 3'd7) begin
                  state    <= ST_DONE;
                  rvalid   <= 1'b0;
                  done     <= 1'b1;
                  word_idx <= 3'd0;
               end else begin
                  rdata    <= mem[rd_addr];
                  word_idx <= rd_k;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Storage is never cleared; a reset in the DONE cycle suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_DONE && wr_q)
         mem[addr_q] <= wdata_q;
   end

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: directed scenarios plus random traffic against a word-level memory model.
module tb_mem_block_responder;
   localparam int AW = 16;
   localparam int L  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, wr0, wr1;
   logic [AW-1:0] addr0, addr1;
   logic [15:0]   wdata0, wdata1;
   logic          arbiter_select, busy, rvalid, done;
   logic [15:0]   rdata;
   logic [2:0]    word_idx;

   int checks = 0;
   int errors = 0;
   logic [15:0] model [int];
   bit last_grant;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   mem_block_responder #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .arbiter_select(arbiter_select), .busy(busy), .rdata(rdata),
      .rvalid(rvalid), .word_idx(word_idx), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic set_port(input int port, input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
      if (port == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
      else           begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic check_all_zero(input string name);
      checks++; if (arbiter_select !== 1'b0) begin errors++; $display("FAIL %s arbiter_select got %b exp 0", name, arbiter_select); end
      checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL %s busy got %b exp 0", name, busy); end
      checks++; if (rdata !== 16'h0)         begin errors++; $display("FAIL %s rdata got %h exp 0000", name, rdata); end
      checks++; if (rvalid !== 1'b0)         begin errors++; $display("FAIL %s rvalid got %b exp 0", name, rvalid); end
      checks++; if (word_idx !== 3'd0)       begin errors++; $display("FAIL %s word_idx got %0d exp 0", name, word_idx); end
      checks++; if (done !== 1'b0)           begin errors++; $display("FAIL %s done got %b exp 0", name, done); end
   endtask

   // Called at the negedge of the accept cycle with the port's request already driven.
   task automatic run_txn(input int port, input string name, input int drop_at, input int abort_at);
      bit          w;
      logic [15:0] a, d, exp_d;
      int          fin, k, key;
      bit          exp_v;
      w   = (port == 0) ? wr0 : wr1;
      a   = (port == 0) ? addr0 : addr1;
      d   = (port == 0) ? wdata0 : wdata1;
      fin = w ? L : L + 8;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s accept-cycle busy got %b exp 0", name, busy); end
      last_grant = port[0];
      for (int off = 1; off <= fin; off++) begin
         @(negedge clk);
         if (off == 1) set_port(port, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
         k     = off - L;
         exp_v = !w && off >= L && off <= L + 7;
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL %s off=%0d busy got %b exp 1", name, off, busy); end
         checks++;
         if (arbiter_select !== 1'(port)) begin errors++; $display("FAIL %s off=%0d arbiter_select got %b exp %0d", name, off, arbiter_select, port); end
         checks++;
         if (rvalid !== exp_v) begin errors++; $display("FAIL %s off=%0d rvalid got %b exp %b", name, off, rvalid, exp_v); end
         checks++;
         if (done !== (off == fin)) begin errors++; $display("FAIL %s off=%0d done got %b exp %b", name, off, done, off == fin); end
         checks++;
         if (word_idx !== (exp_v ? 3'(k) : 3'd0)) begin errors++; $display("FAIL %s off=%0d word_idx got %0d exp %0d", name, off, word_idx, exp_v ? k : 0); end
         if (exp_v) begin
            key = (int'(a) / 16) * 8 + k;
            if (model.exists(key)) begin
               exp_d = model[key];
               checks++;
               if (rdata !== exp_d) begin errors++; $display("FAIL %s off=%0d rdata got %h exp %h", name, off, rdata, exp_d); end
            end
         end
         if (off == drop_at || off == fin) begin
            if (port == 0) req0 = 1'b0; else req1 = 1'b0;
         end
         if (off == abort_at) begin
            rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            check_all_zero({name, " after reset"});
            rst = 1'b0;
            last_grant = 1'b0;
            return;
         end
      end
      if (w) model[int'(a) / 2] = d;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      set_port(0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      set_port(1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
      set_port(0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      set_port(1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      last_grant = 1'b0;
   endtask

   task automatic test_block_read();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         set_port(0, 1'b1, 1'b1, 16'h0040 + 16'(2 * i), 16'hA000 + 16'(i));
         run_txn(0, "preload", 0, 0);
      end
      @(negedge clk);
      set_port(0, 1'b1, 1'b0, 16'h0046, 16'h0);
      run_txn(0, "block_read", 0, 0);
   endtask

   task automatic test_write_read();
      @(negedge clk);
      set_port(0, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
      run_txn(0, "write_beef", 0, 0);
      @(negedge clk);
      set_port(1, 1'b1, 1'b0, 16'h1230, 16'h0);
      run_txn(1, "read_after_write", 0, 0);
   endtask

   task automatic test_contention();
      int win;
      for (int pair = 0; pair < 2; pair++) begin
         @(negedge clk);
         set_port(0, 1'b1, 1'b0, 16'h0040, 16'h0);
         set_port(1, 1'b1, 1'b0, 16'h1230, 16'h0);
         win = RR ? int'(~last_grant) : 0;
         run_txn(win, "contention_first", 0, 0);
         @(negedge clk);
         run_txn(1 - win, "contention_second", 0, 0);
      end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      set_port(0, 1'b1, 1'b0, 16'h0046, 16'h0);
      run_txn(0, "mid_burst", 0, 6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_abort cycle %0d done/busy got %b%b exp 00", i, done, busy); end
      end
      set_port(0, 1'b1, 1'b0, 16'h0046, 16'h0);
      run_txn(0, "fresh_read", 0, 0);
   endtask

   task automatic test_dropped_req();
      @(negedge clk);
      set_port(0, 1'b1, 1'b0, 16'h0046, 16'h0);
      run_txn(0, "dropped_req", 2, 0);
   endtask

   task automatic test_random();
      int p, win;
      bit both;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         p    = int'($urandom_range(0, 1));
         both = ($urandom_range(0, 3) == 0);
         set_port(p, 1'b1, 1'($urandom), 16'($urandom_range(0, 255)), 16'($urandom));
         if (both) begin
            set_port(1 - p, 1'b1, 1'($urandom), 16'($urandom_range(0, 255)), 16'($urandom));
            win = RR ? int'(~last_grant) : 0;
            run_txn(win, "random_pair_first", 0, 0);
            @(negedge clk);
            run_txn(1 - win, "random_pair_second", 0, 0);
         end else begin
            run_txn(p, "random", int'($urandom_range(1, 6)), 0);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      set_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
      set_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
      test_reset();
      test_block_read();
      test_write_read();
      test_contention();
      test_reset_mid_burst();
      test_dropped_req();
      test_random();
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
